// File: rtl/boundary_parity_scanner.sv
// boundary_parity_scanner
// Scans one boundary face of the PU lattice, LANES positions per cycle,
// collects the set of distinct cluster roots reached from boundary-touching
// PUs, and reports the parity of the odd clusters among them.
//
// Handshake: go is a single-cycle request that is accepted only in IDLE and
// ignored everywhere else. busy is high from the cycle after acceptance
// through DONE. done pulses for exactly one cycle, S+3 cycles after go was
// sampled. final_cardinality and root_error are valid from DONE until the
// next accepted go. All data inputs must stay stable from go until done.
// Requires max(CODE_DISTANCE_X, CODE_DISTANCE_Z) >= 2.
module boundary_parity_scanner #(
  parameter int CODE_DISTANCE_X = 4,
  parameter int CODE_DISTANCE_Z = 12,
  parameter int BOUNDARY_TYPE   = 0,
  parameter int LANES           = 4,
  localparam int R        = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
  localparam int PDW      = $clog2(R),
  localparam int AW       = 3 * PDW,
  localparam int PU_COUNT = CODE_DISTANCE_X * CODE_DISTANCE_Z * R
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         go,
  input  logic [PU_COUNT-1:0]          is_touching_boundaries,
  input  logic [PU_COUNT-1:0]          is_odd_cardinalities,
  input  logic [PU_COUNT-1:0][AW-1:0]  roots,
  output logic                         busy,
  output logic                         done,
  output logic                         final_cardinality,
  output logic                         root_error
);

  localparam int N_B = (BOUNDARY_TYPE != 0) ? CODE_DISTANCE_Z * R : CODE_DISTANCE_X * R;
  localparam int S   = (N_B + LANES - 1) / LANES;
  localparam int CW  = (S > 1) ? $clog2(S) : 1;
  localparam int IW  = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SCAN   = 3'd1;
  localparam logic [2:0] ST_DRAIN1 = 3'd2;
  localparam logic [2:0] ST_DRAIN2 = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Boundary position -> PU linear index for the selected face.
  function automatic int pos_to_idx(input int p);
    if (BOUNDARY_TYPE == 0)
      return (p % CODE_DISTANCE_X) * CODE_DISTANCE_Z
           + (p / CODE_DISTANCE_X) * CODE_DISTANCE_Z * CODE_DISTANCE_X;
    else
      return (p % CODE_DISTANCE_Z)
           + (p / CODE_DISTANCE_Z) * CODE_DISTANCE_Z * CODE_DISTANCE_X;
  endfunction

  // Root address fields: [PDW-1:0]=j, [2PDW-1:PDW]=i, [3PDW-1:2PDW]=k.
  function automatic logic root_in_range(input logic [AW-1:0] rt);
    return (int'(rt[2*PDW-1:PDW])    < CODE_DISTANCE_X) &&
           (int'(rt[PDW-1:0])        < CODE_DISTANCE_Z) &&
           (int'(rt[3*PDW-1:2*PDW])  < R);
  endfunction

  function automatic int root_to_idx(input logic [AW-1:0] rt);
    return int'(rt[2*PDW-1:PDW]) * CODE_DISTANCE_Z
         + int'(rt[PDW-1:0])
         + int'(rt[3*PDW-1:2*PDW]) * CODE_DISTANCE_Z * CODE_DISTANCE_X;
  endfunction

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                go_accept;

  logic [LANES-1:0]    s1_valid_q, s1_valid_d;
  logic [AW-1:0]       s1_root_q [LANES];
  logic [AW-1:0]       s1_root_d [LANES];

  logic [PU_COUNT-1:0] bitmap_q, bitmap_d;
  logic                err_q, err_d;
  logic                fc_q;

  assign go_accept = (state_q == ST_IDLE) && go;

  // Control FSM: IDLE -> SCAN (S cycles) -> DRAIN1 -> DRAIN2 -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q == CW'(S - 1)) state_d = ST_DRAIN1;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      ST_DRAIN1: state_d = ST_DRAIN2;
      ST_DRAIN2: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state and scan-cycle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage 1 lookup: each enabled lane fetches the root of a touching boundary PU.
  always_comb begin : stage1_comb
    int p;
    int idx;
    p   = 0;
    idx = 0;
    s1_valid_d = '0;
    for (int l = 0; l < LANES; l++) begin
      s1_root_d[l] = '0;
      p = int'(cnt_q) * LANES + l;
      if ((state_q == ST_SCAN) && (p < N_B)) begin
        idx = pos_to_idx(p);
        if (is_touching_boundaries[IW'(idx)]) begin
          s1_valid_d[l] = 1'b1;
          s1_root_d[l]  = roots[IW'(idx)];
        end
      end
    end
  end

  // Stage 1 registers; only the valid bits need clearing on reset.
  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= '0;
    else       s1_valid_q <= s1_valid_d;
  end

  // Stage 1 root payload.
  always_ff @(posedge clk) begin
    s1_root_q <= s1_root_d;
  end

  // Stage 2 merge: OR valid roots into the bitmap so each root counts once.
  always_comb begin : stage2_comb
    int r;
    r        = 0;
    bitmap_d = bitmap_q;
    err_d    = err_q;
    if (go_accept) begin
      bitmap_d = '0;
      err_d    = 1'b0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (s1_valid_q[l]) begin
          r = root_to_idx(s1_root_q[l]);
          if (root_in_range(s1_root_q[l]) && (r < PU_COUNT))
            bitmap_d[IW'(r)] = 1'b1;
          else
            err_d = 1'b1;
        end
      end
    end
  end

  // Used-root bitmap and sticky root error.
  always_ff @(posedge clk) begin
    if (reset) begin
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

  // Parity of odd used roots, latched once the pipeline has fully drained.
  always_ff @(posedge clk) begin
    if (reset)                       fc_q <= 1'b0;
    else if (state_q == ST_DRAIN2)   fc_q <= ^(bitmap_q & is_odd_cardinalities);
  end

  assign busy              = (state_q != ST_IDLE);
  assign done              = (state_q == ST_DONE);
  assign final_cardinality = fc_q;
  assign root_error        = err_q;

endmodule

// File: tb/tb_boundary_parity_scanner.sv
// tb_boundary_parity_scanner
// Three instances (LANES = 4, 1, 5) share stimulus; directed vectors with
// hand-computed parity/error results plus reset and repeated-go sequences.
module tb_boundary_parity_scanner;

  localparam int PU = 576;
  localparam int AWD = 12;
  localparam int ND = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0;
  always #5 clk = ~clk;

  logic [PU-1:0]          touch_v;
  logic [PU-1:0]          odd_v;
  logic [PU-1:0][AWD-1:0] roots_v;
  logic [ND-1:0]          busy_v, done_v, fc_v, err_v;

  boundary_parity_scanner #(.LANES(4)) u_l4 (
    .clk(clk), .reset(reset), .go(go),
    .is_touching_boundaries(touch_v), .is_odd_cardinalities(odd_v), .roots(roots_v),
    .busy(busy_v[0]), .done(done_v[0]), .final_cardinality(fc_v[0]), .root_error(err_v[0]));

  boundary_parity_scanner #(.LANES(1)) u_l1 (
    .clk(clk), .reset(reset), .go(go),
    .is_touching_boundaries(touch_v), .is_odd_cardinalities(odd_v), .roots(roots_v),
    .busy(busy_v[1]), .done(done_v[1]), .final_cardinality(fc_v[1]), .root_error(err_v[1]));

  boundary_parity_scanner #(.LANES(5)) u_l5 (
    .clk(clk), .reset(reset), .go(go),
    .is_touching_boundaries(touch_v), .is_odd_cardinalities(odd_v), .roots(roots_v),
    .busy(busy_v[2]), .done(done_v[2]), .final_cardinality(fc_v[2]), .root_error(err_v[2]));

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int lat_exp [ND];
  logic prev_fc = 1'b0;

  typedef struct packed {
    logic [2:0]       cnt;
    logic [3:0][9:0]  pu;
    logic [3:0][3:0]  ri;
    logic [3:0][3:0]  rj;
    logic [3:0][3:0]  rk;
    logic [3:0]       odd;
    logic             exp_fc;
    logic             exp_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  function automatic int pidx(input int i, input int j, input int k);
    return i * 12 + j + k * 48;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_entry(input int v, input int e, input int pu, input int ri,
                           input int rj, input int rk, input logic odd);
    vecs[v].pu[e]  = 10'(pu);
    vecs[v].ri[e]  = 4'(ri);
    vecs[v].rj[e]  = 4'(rj);
    vecs[v].rk[e]  = 4'(rk);
    vecs[v].odd[e] = odd;
  endtask

  task automatic apply_vec(input int v);
    int p;
    touch_v = '0;
    odd_v   = '0;
    roots_v = '0;
    for (int e = 0; e < int'(vecs[v].cnt); e++) begin
      p = int'(vecs[v].pu[e]);
      touch_v[p] = 1'b1;
      roots_v[p] = {vecs[v].rk[e], vecs[v].ri[e], vecs[v].rj[e]};
      if (vecs[v].odd[e])
        odd_v[pidx(int'(vecs[v].ri[e]), int'(vecs[v].rj[e]), int'(vecs[v].rk[e]))] = 1'b1;
    end
  endtask

  // Pulse go, optionally re-pulse it at cycle go_again, watch all instances for 60 cycles.
  task automatic run_scan(input string tag, input logic exp_fc, input logic exp_err,
                          input int go_again);
    int   dcnt [ND];
    int   dcyc [ND];
    logic fc_at [ND];
    logic err_at [ND];
    for (int n = 0; n < ND; n++) begin
      dcnt[n] = 0; dcyc[n] = -1; fc_at[n] = 1'b0; err_at[n] = 1'b0;
    end
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int n = 0; n < ND; n++) begin
      check($sformatf("%s busy_rise d%0d", tag, n), int'(busy_v[n]), 1);
      check($sformatf("%s fc_hold d%0d", tag, n), int'(fc_v[n]), int'(prev_fc));
    end
    for (int cyc = 1; cyc <= 60; cyc++) begin
      go = (cyc == go_again);
      for (int n = 0; n < ND; n++) begin
        if (done_v[n]) begin
          dcnt[n]++;
          dcyc[n]   = cyc;
          fc_at[n]  = fc_v[n];
          err_at[n] = err_v[n];
        end
      end
      @(negedge clk);
    end
    go = 1'b0;
    for (int n = 0; n < ND; n++) begin
      check($sformatf("%s done_count d%0d", tag, n), dcnt[n], 1);
      check($sformatf("%s done_latency d%0d", tag, n), dcyc[n], lat_exp[n]);
      check($sformatf("%s final_cardinality d%0d", tag, n), int'(fc_at[n]), int'(exp_fc));
      check($sformatf("%s root_error d%0d", tag, n), int'(err_at[n]), int'(exp_err));
      check($sformatf("%s fc_after d%0d", tag, n), int'(fc_v[n]), int'(exp_fc));
      check($sformatf("%s busy_idle d%0d", tag, n), int'(busy_v[n]), 0);
    end
    prev_fc = exp_fc;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dseen [ND];
    lat_exp[0] = 15;  // S=12
    lat_exp[1] = 51;  // S=48
    lat_exp[2] = 13;  // S=10

    vecs = '{default: '0};
    // V0: nothing touching
    vecs[0].cnt = 3'd0; vecs[0].exp_fc = 1'b0; vecs[0].exp_err = 1'b0;
    // V1: two boundary PUs sharing odd root (3,4,2) -> counted once
    vecs[1].cnt = 3'd2; vecs[1].exp_fc = 1'b1; vecs[1].exp_err = 1'b0;
    set_entry(1, 0, pidx(1,0,0), 3, 4, 2, 1'b1);
    set_entry(1, 1, pidx(2,0,5), 3, 4, 2, 1'b1);
    // V2: two distinct odd roots, second one via the last boundary position
    vecs[2].cnt = 3'd2; vecs[2].exp_fc = 1'b0; vecs[2].exp_err = 1'b0;
    set_entry(2, 0, pidx(0,0,0), 1, 1, 1, 1'b1);
    set_entry(2, 1, pidx(3,0,11), 2, 5, 7, 1'b1);
    // V3: V2 plus a third odd root
    vecs[3] = vecs[2]; vecs[3].cnt = 3'd3; vecs[3].exp_fc = 1'b1;
    set_entry(3, 2, pidx(1,0,3), 0, 11, 11, 1'b1);
    // V4: V3 plus a touched even root
    vecs[4] = vecs[3]; vecs[4].cnt = 3'd4;
    set_entry(4, 3, pidx(2,0,2), 1, 2, 3, 1'b0);
    // V5: k=13 root flagged as error, remaining lane still counted
    vecs[5].cnt = 3'd2; vecs[5].exp_fc = 1'b1; vecs[5].exp_err = 1'b1;
    set_entry(5, 0, pidx(0,0,0), 0, 0, 13, 1'b0);
    set_entry(5, 1, pidx(1,0,0), 3, 4, 2, 1'b1);
    // V6: touching PU off the face (j=5) is never scanned
    vecs[6].cnt = 3'd1; vecs[6].exp_fc = 1'b0; vecs[6].exp_err = 1'b0;
    set_entry(6, 0, pidx(0,5,0), 3, 4, 2, 1'b1);
    // V7: i field out of range and j field out of range
    vecs[7].cnt = 3'd2; vecs[7].exp_fc = 1'b0; vecs[7].exp_err = 1'b1;
    set_entry(7, 0, pidx(3,0,0), 5, 0, 0, 1'b0);
    set_entry(7, 1, pidx(0,0,1), 0, 12, 0, 1'b0);

    touch_v = '0; odd_v = '0; roots_v = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int n = 0; n < ND; n++) begin
      check($sformatf("reset busy d%0d", n), int'(busy_v[n]), 0);
      check($sformatf("reset done d%0d", n), int'(done_v[n]), 0);
      check($sformatf("reset fc d%0d", n), int'(fc_v[n]), 0);
      check($sformatf("reset err d%0d", n), int'(err_v[n]), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    for (int v = 0; v < NV; v++) begin
      apply_vec(v);
      run_scan($sformatf("vec%0d", v), vecs[v].exp_fc, vecs[v].exp_err, -1);
    end

    // Repeated go during SCAN is ignored
    apply_vec(4);
    run_scan("go_again", vecs[4].exp_fc, vecs[4].exp_err, 3);

    // Reset in DRAIN1 (LANES=4 instance) aborts with no done and clears outputs
    apply_vec(1);
    run_scan("pre_reset", 1'b1, 1'b0, -1);
    apply_vec(5);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int cyc = 1; cyc < 13; cyc++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < ND; n++) begin
      dseen[n] = 0;
      check($sformatf("abort busy d%0d", n), int'(busy_v[n]), 0);
      check($sformatf("abort fc d%0d", n), int'(fc_v[n]), 0);
      check($sformatf("abort err d%0d", n), int'(err_v[n]), 0);
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      for (int n = 0; n < ND; n++) if (done_v[n]) dseen[n]++;
      @(negedge clk);
    end
    for (int n = 0; n < ND; n++)
      check($sformatf("abort no_done d%0d", n), dseen[n], 0);
    prev_fc = 1'b0;

    // Normal operation resumes after the abort
    apply_vec(3);
    run_scan("post_reset", vecs[3].exp_fc, vecs[3].exp_err, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
